// File: rtl/mlp_layer_tm_pkg.sv
// Shared types and helpers for the time-multiplexed MLP layer.
// Helpers work in 64-bit signed space, so DW must stay well below 32.
package mlp_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, FIN, OUT} state_t;

  localparam int ACT_LINEAR = 0;
  localparam int ACT_RELU   = 1;

  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int v);
    return (v > 1) ? clog2(v) : 1;
  endfunction

  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mlp_layer_tm_if.sv
// Config, input-sample and result streams of the MLP layer.
interface mlp_layer_tm_if #(
  parameter int DW = 16,
  parameter int IW = 4
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [31:0]   cfg_layer;
  logic [31:0]   cfg_neuron;
  logic [31:0]   cfg_addr;
  logic          cfg_bias;
  logic [DW-1:0] cfg_data;
  logic          x_valid;
  logic          x_ready;
  logic [DW-1:0] x_in;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic [IW-1:0] o_idx;
  logic          busy;

  modport master (
    output cfg_valid, cfg_layer, cfg_neuron, cfg_addr, cfg_bias, cfg_data,
    input  cfg_ready,
    output x_valid, x_in,
    input  x_ready,
    input  o_valid, o_data, o_idx,
    output o_ready,
    input  busy
  );

  modport slave (
    input  cfg_valid, cfg_layer, cfg_neuron, cfg_addr, cfg_bias, cfg_data,
    output cfg_ready,
    input  x_valid, x_in,
    output x_ready,
    output o_valid, o_data, o_idx,
    input  o_ready,
    output busy
  );
endinterface

// File: rtl/mlp_layer_tm_lane_mac.sv
// One MAC lane: weight/bias storage for neurons LANE, LANE+LANES, ...,
// the accumulator, and the bias/shift/saturate/activation stage.
module mlp_lane_mac
  import mlp_pkg::*;
#(
  parameter int NN     = 10,
  parameter int NUM_IN = 30,
  parameter int DW     = 16,
  parameter int FRAC   = 8,
  parameter int LANES  = 4,
  parameter int LANE   = 0,
  parameter int ACT    = ACT_RELU,
  localparam int NPASS = (NN + LANES - 1) / LANES,
  localparam int PW    = idx_w(NPASS),
  localparam int CW    = idx_w(NUM_IN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_bias,
  input  logic [PW-1:0] wr_slot,
  input  logic [CW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          mac_en,
  input  logic          acc_clr,
  input  logic [PW-1:0] pass,
  input  logic [CW-1:0] k,
  input  logic [DW-1:0] x,
  input  logic          fin_en,
  output logic [DW-1:0] res
);
  localparam int DEPTH = NPASS * NUM_IN;
  localparam int RAW   = idx_w(DEPTH);
  localparam int AW    = 2 * DW + clog2(NUM_IN + 1) + 1;

  logic [DW-1:0] w_ram [DEPTH];
  logic [DW-1:0] b_ram [NPASS];
  logic [RAW-1:0] waddr, raddr;
  logic signed [AW-1:0] acc;
  logic signed [2*DW-1:0] xs, ws, prod;
  logic signed [63:0] s;
  logic [DW-1:0] b_rd;
  logic active;

  assign waddr  = RAW'(int'(wr_slot) * NUM_IN + int'(wr_addr));
  assign raddr  = RAW'(int'(pass) * NUM_IN + int'(k));
  assign active = (int'(pass) * LANES + LANE) < NN;

  // Storage is deliberately not reset so coefficients survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bias) b_ram[wr_slot] <= wr_data;
      else         w_ram[waddr]   <= wr_data;
    end
  end

  assign xs   = {{DW{x[DW-1]}}, x};
  assign ws   = {{DW{w_ram[raddr][DW-1]}}, w_ram[raddr]};
  assign prod = xs * ws;
  assign b_rd = b_ram[pass];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   acc <= '0;
    else if (acc_clr)          acc <= '0;
    else if (mac_en && active) acc <= acc + {{(AW-2*DW){prod[2*DW-1]}}, prod};
  end

  // Bias is aligned to the product scale (2*FRAC) before the final shift.
  always_comb begin
    s = {{(64-AW){acc[AW-1]}}, acc} + ({{(64-DW){b_rd[DW-1]}}, b_rd} << FRAC);
    s = s >>> FRAC;
    s = sat_dw(s, DW);
    if (ACT == ACT_RELU && s < 0) s = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         res <= '0;
    else if (fin_en) res <= s[DW-1:0];
  end

endmodule

// File: rtl/mlp_layer_tm.sv
// Fully-connected layer: NN neurons time-shared over LANES MAC lanes,
// one buffered input vector per run, results streamed with neuron index.
module mlp_layer_tm
  import mlp_pkg::*;
#(
  parameter int NN        = 10,
  parameter int NUM_IN    = 30,
  parameter int DW        = 16,
  parameter int FRAC      = 8,
  parameter int LANES     = 4,
  parameter int LAYER_NUM = 3,
  parameter int ACT       = ACT_RELU
) (
  input logic          clk,
  input logic          rst,
  mlp_layer_tm_if.slave bus
);
  localparam int NPASS = (NN + LANES - 1) / LANES;
  localparam int CW    = idx_w(NUM_IN);
  localparam int PW    = idx_w(NPASS);
  localparam int LW    = idx_w(LANES);
  localparam int IW    = idx_w(NN);

  state_t        state;
  logic [CW-1:0] cnt, x_wi, wr_addr;
  logic [PW-1:0] pass, wr_slot;
  logic [LW-1:0] lsel;
  logic          o_valid;
  logic [IW-1:0] o_idx;
  logic [DW-1:0] o_data;
  logic [DW-1:0] x_buf [NUM_IN];
  logic [LANES-1:0][DW-1:0] res;
  logic [LANES-1:0] lane_wr;
  logic x_fire, cfg_ok, acc_clr, nxt_ok;

  assign bus.x_ready   = (state == IDLE) || (state == LOAD);
  assign bus.cfg_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.o_valid   = o_valid;
  assign bus.o_idx     = o_idx;
  assign bus.o_data    = o_data;

  assign x_fire  = bus.x_valid && bus.x_ready;
  assign cfg_ok  = bus.cfg_valid && bus.cfg_ready && (bus.cfg_layer == 32'(LAYER_NUM)) &&
                   (bus.cfg_neuron < 32'(NN)) && (bus.cfg_bias || bus.cfg_addr < 32'(NUM_IN));
  assign wr_slot = PW'(bus.cfg_neuron / 32'(LANES));
  assign wr_addr = CW'(bus.cfg_addr);
  assign x_wi    = (state == IDLE) ? '0 : cnt;
  // Accumulators idle at zero everywhere except MAC/FIN, so every pass starts clean.
  assign acc_clr = (state == IDLE) || (state == LOAD) || (state == OUT);

  always_ff @(posedge clk) begin
    if (x_fire) x_buf[x_wi] <= bus.x_in;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_wr[l] = cfg_ok && (bus.cfg_neuron % 32'(LANES) == 32'(l));
    mlp_lane_mac #(
      .NN(NN), .NUM_IN(NUM_IN), .DW(DW), .FRAC(FRAC),
      .LANES(LANES), .LANE(l), .ACT(ACT)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (lane_wr[l]),
      .wr_bias (bus.cfg_bias),
      .wr_slot (wr_slot),
      .wr_addr (wr_addr),
      .wr_data (bus.cfg_data),
      .mac_en  (state == MAC),
      .acc_clr (acc_clr),
      .pass    (pass),
      .k       (cnt),
      .x       (x_buf[cnt]),
      .fin_en  (state == FIN),
      .res     (res[l])
    );
  end

  // Output data is a mux over the lane result registers, held by lsel.
  always_comb begin
    o_data = '0;
    nxt_ok = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (l == int'(lsel)) o_data = res[l];
      if (l == int'(lsel) + 1 && int'(pass) * LANES + l < NN) nxt_ok = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pass    <= '0;
      lsel    <= '0;
      o_valid <= 1'b0;
      o_idx   <= '0;
    end else begin
      case (state)
        IDLE: if (x_fire) begin
          pass <= '0;
          if (NUM_IN > 1) begin
            state <= LOAD;
            cnt   <= CW'(1);
          end else begin
            state <= MAC;
            cnt   <= '0;
          end
        end
        LOAD: if (x_fire) begin
          if (cnt == CW'(NUM_IN - 1)) begin
            state <= MAC;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MAC: begin
          if (cnt == CW'(NUM_IN - 1)) begin
            state <= FIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          state   <= OUT;
          o_valid <= 1'b1;
          lsel    <= '0;
          o_idx   <= IW'(int'(pass) * LANES);
        end
        OUT: if (bus.o_ready) begin
          if (nxt_ok) begin
            lsel  <= lsel + 1'b1;
            o_idx <= o_idx + 1'b1;
          end else begin
            o_valid <= 1'b0;
            if (int'(pass) < NPASS - 1) begin
              pass  <= pass + 1'b1;
              state <= MAC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_layer_tm.sv
// Bench for mlp_layer_tm: a ReLU and a linear instance share one stimulus
// stream; a reference model fills per-instance scoreboards.
module tb_mlp_layer_tm;
  localparam int NN = 3;
  localparam int NI = 4;
  localparam int LN = 2;
  localparam int DW = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mlp_layer_tm_if #(.DW(DW), .IW(IW)) bi ();
  mlp_layer_tm_if #(.DW(DW), .IW(IW)) bl ();

  assign bl.cfg_valid  = bi.cfg_valid;
  assign bl.cfg_layer  = bi.cfg_layer;
  assign bl.cfg_neuron = bi.cfg_neuron;
  assign bl.cfg_addr   = bi.cfg_addr;
  assign bl.cfg_bias   = bi.cfg_bias;
  assign bl.cfg_data   = bi.cfg_data;
  assign bl.x_valid    = bi.x_valid;
  assign bl.x_in       = bi.x_in;
  assign bl.o_ready    = bi.o_ready;

  mlp_layer_tm #(.NN(NN), .NUM_IN(NI), .DW(DW), .FRAC(8), .LANES(LN), .LAYER_NUM(3), .ACT(1))
    dut_relu (.clk(clk), .rst(rst), .bus(bi));
  mlp_layer_tm #(.NN(NN), .NUM_IN(NI), .DW(DW), .FRAC(8), .LANES(LN), .LAYER_NUM(3), .ACT(0))
    dut_lin (.clk(clk), .rst(rst), .bus(bl));

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] d;
  } exp_t;

  exp_t q_r[$];
  exp_t q_l[$];
  int total = 0;
  int bad = 0;
  logic signed [DW-1:0] tw [NN][NI];
  logic signed [DW-1:0] tb_b [NN];
  logic signed [DW-1:0] xv [NI];

  function automatic logic [DW-1:0] ref_out(input int n, input bit relu);
    longint a;
    a = 0;
    for (int k = 0; k < NI; k++) a += longint'(tw[n][k]) * longint'(xv[k]);
    a += longint'(tb_b[n]) * 256;
    a = a >>> 8;
    if (a > 32767) a = 32767;
    if (a < -32768) a = -32768;
    if (relu && a < 0) a = 0;
    return a[DW-1:0];
  endfunction

  task automatic cfg_wr(input int layer, input int neuron, input int addr, input bit bias,
                        input logic [DW-1:0] d);
    bit accept;
    @(negedge clk);
    bi.cfg_valid = 1'b1; bi.cfg_layer = 32'(layer); bi.cfg_neuron = 32'(neuron);
    bi.cfg_addr = 32'(addr); bi.cfg_bias = bias; bi.cfg_data = d;
    accept = bi.cfg_ready && layer == 3 && neuron >= 0 && neuron < NN && (bias || (addr >= 0 && addr < NI));
    @(posedge clk);
    #1 bi.cfg_valid = 1'b0;
    if (accept) begin
      if (bias) tb_b[neuron] = d;
      else      tw[neuron][addr] = d;
    end
  endtask

  task automatic load_all(input logic [DW-1:0] w, input logic [DW-1:0] b);
    for (int n = 0; n < NN; n++) begin
      for (int k = 0; k < NI; k++) cfg_wr(3, n, k, 1'b0, w);
      cfg_wr(3, n, 0, 1'b1, b);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int n = 0; n < NN; n++) begin
      e.idx = IW'(n); e.d = ref_out(n, 1'b1); q_r.push_back(e);
      e.d = ref_out(n, 1'b0); q_l.push_back(e);
    end
  endtask

  // Ends on the negedge right after the final sample handshake.
  task automatic send_vec(input bit gaps);
    int cyc;
    for (int i = 0; i < NI; i++) begin
      if (gaps && (i % 2 == 1)) begin
        @(negedge clk); bi.x_valid = 1'b0;
      end
      @(negedge clk);
      bi.x_valid = 1'b1; bi.x_in = xv[i];
      cyc = 0;
      while (!bi.x_ready && cyc < 100) begin @(negedge clk); cyc++; end
      if (!bi.x_ready) begin
        total++; bad++;
        $display("FAIL x_ready_timeout sample=%0d x_ready=%b want 1", i, bi.x_ready);
      end
      @(posedge clk);
    end
    @(negedge clk);
    bi.x_valid = 1'b0;
  endtask

  task automatic wait_first(output int lat);
    lat = 0;
    while (!bi.o_valid && lat < 200) begin @(negedge clk); lat++; end
  endtask

  task automatic drain(input int beats, input bit rnd);
    int got = 0;
    int cyc = 0;
    exp_t e;
    while (got < beats && cyc < 1000) begin
      @(negedge clk); cyc++;
      bi.o_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (bi.o_valid && bi.o_ready) begin
        got++;
        total++;
        if (q_r.size() == 0) begin
          bad++; $display("FAIL relu_extra_beat idx=%0d data=%h want none", bi.o_idx, bi.o_data);
        end else begin
          e = q_r.pop_front();
          if (bi.o_data !== e.d || bi.o_idx !== e.idx) begin
            bad++;
            $display("FAIL relu_beat got idx=%0d data=%h want idx=%0d data=%h", bi.o_idx, bi.o_data, e.idx, e.d);
          end
        end
        total++;
        if (q_l.size() == 0) begin
          bad++; $display("FAIL lin_extra_beat idx=%0d data=%h want none", bl.o_idx, bl.o_data);
        end else begin
          e = q_l.pop_front();
          if (bl.o_valid !== 1'b1 || bl.o_data !== e.d || bl.o_idx !== e.idx) begin
            bad++;
            $display("FAIL lin_beat got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h",
                     bl.o_valid, bl.o_idx, bl.o_data, e.idx, e.d);
          end
        end
      end
    end
    @(negedge clk);
    bi.o_ready = 1'b0;
    cyc = 0;
    while ((bi.busy || bl.busy) && cyc < 20) begin @(negedge clk); cyc++; end
    total++;
    if (got != beats || bi.busy !== 1'b0 || bl.busy !== 1'b0 || bi.o_valid !== 1'b0 ||
        q_r.size() != 0 || q_l.size() != 0) begin
      bad++;
      $display("FAIL run_end beats=%0d busy=%b/%b o_valid=%b left=%0d/%0d want beats=%0d idle empty",
               got, bi.busy, bl.busy, bi.o_valid, q_r.size(), q_l.size(), beats);
    end
  endtask

  task automatic run_vec(input bit gaps, input bit rnd, input bit chk_lat);
    int lat;
    push_exp();
    send_vec(gaps);
    wait_first(lat);
    if (chk_lat) begin
      total++;
      if (lat != 5) begin
        bad++; $display("FAIL first_latency got=%0d want=5", lat);
      end
    end
    drain(NN, rnd);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bi.o_valid !== 1'b0 || bi.o_data !== 16'h0 || bi.o_idx !== 2'd0) begin
      bad++; $display("FAIL reset_out v=%b d=%h i=%0d want 0 0 0", bi.o_valid, bi.o_data, bi.o_idx);
    end
    total++;
    if (bi.busy !== 1'b0 || bi.x_ready !== 1'b1 || bi.cfg_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ctrl busy=%b xr=%b cr=%b want 0 1 1", bi.busy, bi.x_ready, bi.cfg_ready);
    end
    total++;
    if (bl.o_valid !== 1'b0 || bl.busy !== 1'b0 || bl.x_ready !== 1'b1 || bl.o_data !== 16'h0) begin
      bad++; $display("FAIL reset_lin v=%b busy=%b xr=%b d=%h want 0 0 1 0", bl.o_valid, bl.busy, bl.x_ready, bl.o_data);
    end
  endtask

  task automatic test_basic();
    load_all(16'h0100, 16'h0000);
    xv[0] = 16'h0100; xv[1] = 16'h0200; xv[2] = 16'h0300; xv[3] = 16'h0400;
    run_vec(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_neg_bias();
    for (int k = 0; k < NI; k++) cfg_wr(3, 1, k, 1'b0, 16'hFF00);
    cfg_wr(3, 1, 0, 1'b1, 16'h0100);
    run_vec(1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [DW-1:0] d0;
    logic [IW-1:0] i0;
    push_exp();
    send_vec(1'b0);
    wait_first(lat);
    bi.o_ready = 1'b0;
    d0 = bi.o_data; i0 = bi.o_idx;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bi.cfg_valid = 1'b1; bi.cfg_bias = 1'b0; bi.cfg_addr = 32'(c % NI); bi.cfg_data = 16'h1234;
      bi.cfg_layer  = (c % 3 == 0) ? 32'd2 : 32'd3;
      bi.cfg_neuron = (c % 3 == 1) ? 32'(NN) : 32'd0;
      total++;
      if (bi.o_valid !== 1'b1 || bi.o_data !== d0 || bi.o_idx !== i0 ||
          bi.x_ready !== 1'b0 || bi.cfg_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold c=%0d v=%b d=%h i=%0d xr=%b cr=%b want 1 %h %0d 0 0",
                 c, bi.o_valid, bi.o_data, bi.o_idx, bi.x_ready, bi.cfg_ready, d0, i0);
      end
    end
    bi.cfg_valid = 1'b0;
    drain(NN, 1'b0);
  endtask

  task automatic test_cfg_ignore();
    cfg_wr(2, 0, 0, 1'b0, 16'h5555);
    cfg_wr(3, NN, 0, 1'b0, 16'h5555);
    cfg_wr(3, 0, NI, 1'b0, 16'h5555);
    cfg_wr(4, 1, 1, 1'b1, 16'h5555);
    run_vec(1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_saturation();
    load_all(16'h7FFF, 16'h0000);
    for (int k = 0; k < NI; k++) xv[k] = 16'h7FFF;
    run_vec(1'b0, 1'b0, 1'b1);
    load_all(16'h8000, 16'h0000);
    run_vec(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < NN; n++) begin
      for (int k = 0; k < NI; k++) cfg_wr(3, n, k, 1'b0, 16'($urandom_range(0, 1023)) - 16'd512);
      cfg_wr(3, n, 0, 1'b1, 16'($urandom_range(0, 511)) - 16'd256);
    end
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < NI; k++) xv[k] = 16'($urandom_range(0, 2047)) - 16'd1024;
      run_vec(v[0], 1'b1, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    send_vec(1'b0);
    rst = 1'b1;
    #1;
    total++;
    if (bi.busy !== 1'b0 || bi.o_valid !== 1'b0 || bi.x_ready !== 1'b1 || bl.busy !== 1'b0) begin
      bad++; $display("FAIL rst_in_mac busy=%b v=%b xr=%b lbusy=%b want 0 0 1 0",
                      bi.busy, bi.o_valid, bi.x_ready, bl.busy);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); bi.x_valid = 1'b1; bi.x_in = 16'h7777;
    @(posedge clk);
    @(negedge clk); bi.x_in = 16'h6666;
    @(posedge clk);
    @(negedge clk); bi.x_valid = 1'b0; rst = 1'b1;
    #1;
    total++;
    if (bi.busy !== 1'b0 || bi.x_ready !== 1'b1 || bi.cfg_ready !== 1'b1) begin
      bad++; $display("FAIL rst_in_load busy=%b xr=%b cr=%b want 0 1 1", bi.busy, bi.x_ready, bi.cfg_ready);
    end
    @(negedge clk); rst = 1'b0;
    run_vec(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bi.cfg_valid = 1'b0; bi.cfg_layer = '0; bi.cfg_neuron = '0; bi.cfg_addr = '0;
    bi.cfg_bias = 1'b0; bi.cfg_data = '0; bi.x_valid = 1'b0; bi.x_in = '0; bi.o_ready = 1'b0;
    for (int n = 0; n < NN; n++) begin
      tb_b[n] = '0;
      for (int k = 0; k < NI; k++) tw[n][k] = '0;
    end
    test_reset();
    test_basic();
    test_neg_bias();
    test_backpressure();
    test_cfg_ignore();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mlp_layer_tm.md
Name: mlp_layer_tm

Overview:
Time-multiplexed, fully parametrised fully-connected MLP layer: NN neurons share LANES physical MAC lanes over ceil(NN/LANES) passes.
- Buffers one input vector of NUM_IN samples from a valid/ready stream.
- Computes dot products with runtime-loaded weights and biases, then applies a selectable activation.
- Streams results out tagged with neuron index.
- Replaces per-layer fixed-neuron wrappers; one module serves any layer via LAYER_NUM.

Parameters:
NN, 10, neurons in layer
NUM_IN, 30, inputs (weights) per neuron
DW, 16, data/weight width, signed two's complement
FRAC, 8, fractional bits of data, weight and bias (Q(DW-FRAC).FRAC)
LANES, 4, parallel MAC lanes (1..NN)
LAYER_NUM, 3, layer id matched against cfg_layer
ACT, 1, activation: 0 = linear with saturation, 1 = ReLU with saturation

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  config write strobe
cfg_ready  out  1  config accepted (high only in IDLE)
cfg_layer  in  32  target layer; write ignored unless == LAYER_NUM
cfg_neuron  in  32  target neuron 0..NN-1; write ignored if >= NN
cfg_addr  in  32  weight index 0..NUM_IN-1; ignored when cfg_bias=1
cfg_bias  in  1  1 = write bias, 0 = write weight
cfg_data  in  DW  weight/bias value
x_valid  in  1  input sample valid
x_ready  out  1  input sample accepted
x_in  in  DW  input sample, index order 0..NUM_IN-1
o_valid  out  1  result valid
o_ready  in  1  downstream accepts result
o_data  out  DW  activated neuron output
o_idx  out  clog2(NN)  neuron index of o_data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - State IDLE; all counters 0; accumulators 0.
  - o_valid=0, o_data=0, o_idx=0, busy=0.
  - x_ready=1 and cfg_ready=1 (combinational from IDLE).
  - Weight/bias RAMs are not reset; contents persist across rst.
- Config:
  - Write occurs when cfg_valid & cfg_ready and the layer/neuron/addr checks pass.
  - Ignored writes produce no side effect.
- FSM states: IDLE, LOAD, MAC, FIN, OUT.
  - IDLE: first x_valid&x_ready stores sample 0 and goes to LOAD (LOAD if NUM_IN>1, else MAC).
  - LOAD: x_ready=1; stores one sample per handshake; after sample NUM_IN-1 goes to MAC with pass=0. Gaps in x_valid stall without loss.
  - MAC: NUM_IN cycles, k=0..NUM_IN-1. Lane l (neuron n = pass*LANES+l) does acc += x_buf[k]*w[n][k]. Lanes with n>=NN are idle. Then go to FIN.
  - FIN: 1 cycle. Per lane compute r = (acc + (bias<<FRAC)) >>> FRAC (arithmetic shift, truncation toward -inf), saturate to [-2^(DW-1), 2^(DW-1)-1], apply ReLU if ACT=1. Latch into output regs, then go to OUT.
  - OUT: presents valid lanes in order l=0.., o_idx = pass*LANES+l. Advances on o_valid&o_ready.
    - o_data/o_idx hold stable while o_valid & !o_ready.
    - After the last valid lane: if more passes remain, pass++, accumulators cleared, go to MAC; else go to IDLE.
- Widths:
  - Product 2*DW.
  - Accumulator 2*DW+clog2(NUM_IN+1)+1; no internal overflow possible.
- Timing:
  - Latency from last input accepted to first o_valid is NUM_IN+1 cycles.
  - Each pass costs NUM_IN+1 cycles plus its output beats.
  - x_ready=0 and cfg_ready=0 from MAC through the end of OUT; no input overlap across vectors.
- Reset mid-operation (any state): immediate return to reset values; a partially loaded vector is discarded. The next vector restarts at sample 0.
- o_valid may rise in the FIN→OUT transition cycle only. It is never asserted in other states.

Decomposition:
- Package mlp_pkg:
  - state enum (IDLE, LOAD, MAC, FIN, OUT);
  - ACT_LINEAR=0, ACT_RELU=1;
  - clog2 function;
  - saturate-to-DW function.
- Sub-module mlp_lane_mac: one lane, holding its weight slice RAM, bias reg, accumulator, and FIN arithmetic. Instantiated LANES times via generate. Lane l stores neurons l, l+LANES, ...

Test Plan:
- NN=3, NUM_IN=4, LANES=2. All weights 0x0100, biases 0, inputs 0x0100,0x0200,0x0300,0x0400 → three beats 0x0A00 with o_idx 0,1 (pass 0) then 2 (pass 1); first o_valid exactly 5 cycles after the last x handshake.
- Neuron 1 weights 0xFF00, bias 0x0100, same inputs: ACT=1 → 0x0000; ACT=0 → 0xF700. Neurons 0 and 2 are unchanged at 0x0A00.
- All weights and inputs 0x7FFF → 0x7FFF on every neuron (positive saturation). Weights 0x8000 with inputs 0x7FFF and ACT=0 → 0x8000.
- Hold o_ready=0 for 10 cycles at beat 0: o_valid stays 1 and o_data/o_idx stay stable. x_ready=0 and cfg_ready=0 throughout.
- Config writes with cfg_layer=2, or cfg_neuron=NN, while computing → no weight change. A rerun yields identical results.
- Assert rst in MAC during pass 0: next cycle busy=0, o_valid=0, x_ready=1. Re-sending the same vector reproduces the same outputs, since weights are retained.
